// File: rtl/servo_pwm_capture.sv
// servo_pwm_capture: receive side of a servo PWM link. Synchronizes and
// deglitches the incoming line, measures high time and period in clk cycles,
// validates each frame against the servo timing window, classifies the
// commanded position and flags loss of signal.
module servo_pwm_capture #(
    parameter int PWM_PERIOD = 1_000_000,
    parameter int MIN_DUTY   = 50_000,
    parameter int MAX_DUTY   = 100_000,
    parameter int WIDTH_TOL  = 5_000,
    parameter int PERIOD_TOL = 50_000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [25:0] width,
    output logic [25:0] period,
    output logic [1:0]  pos_state,
    output logic        valid,
    output logic        frame_error,
    output logic        signal_lost
);

    // Run counter spans 0 .. FILTER_LEN-1; the last step toggles the filter.
    localparam int RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);

    localparam logic [25:0] W_LO     = 26'(MIN_DUTY - WIDTH_TOL);
    localparam logic [25:0] W_HI     = 26'(MAX_DUTY + WIDTH_TOL);
    localparam logic [25:0] P_LO     = 26'(PWM_PERIOD - PERIOD_TOL);
    localparam logic [25:0] P_HI     = 26'(PWM_PERIOD + PERIOD_TOL);
    localparam logic [25:0] C_CLOSED = 26'(MIN_DUTY + WIDTH_TOL);
    localparam logic [25:0] C_OPEN   = 26'(MAX_DUTY - WIDTH_TOL);
    localparam logic [25:0] TO_LAST  = 26'(TIMEOUT - 1);
    localparam logic [25:0] TO_MAX   = 26'(TIMEOUT);

    localparam logic [1:0] POS_NONE   = 2'b00;
    localparam logic [1:0] POS_CLOSED = 2'b01;
    localparam logic [1:0] POS_OPEN   = 2'b10;
    localparam logic [1:0] POS_MID    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // Input path
    logic             s1_q, s2_q;
    logic [1:0]       warm_q;
    logic             f_q, f_d, fdly_q;
    logic [RUN_W-1:0] run_q, run_d;
    logic             armed_q, armed_d;

    // Measurement / FSM
    state_t      state_q, state_d;
    logic [25:0] hi_q, hi_d, per_q, per_d, idle_q, idle_d;

    // Registered outputs
    logic [25:0] width_q, width_d, period_q, period_d;
    logic [1:0]  pos_q, pos_d;
    logic        valid_q, valid_d, ferr_q, ferr_d, lost_q, lost_d;

    logic rise, fall, edge_any, timeout_hit, frame_ok;

    function automatic logic [25:0] sat_inc(input logic [25:0] v);
        return (v == '1) ? v : v + 26'd1;
    endfunction

    function automatic logic [1:0] classify(input logic [25:0] w);
        if (w <= C_CLOSED)    return POS_CLOSED;
        else if (w >= C_OPEN) return POS_OPEN;
        else                  return POS_MID;
    endfunction

    // Two-flop synchronizer plus a warm-up marker telling when s2_q holds a real sample.
    // NOTE: reset is in the sensitivity list so every flop clears the instant rst rises, without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            warm_q <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments let s2_q take the old s1_q, forming a real two-stage pipeline.
            s1_q   <= pwm_in;
            s2_q   <= s1_q;
            warm_q <= {warm_q[0], 1'b1};
        end
    end

    // Deglitch filter: follow the synchronized input only after FILTER_LEN differing cycles in a row.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        f_d   = f_q;
        run_d = '0;
        if (s2_q != f_q) begin
            if (run_q == RUN_LAST) f_d   = s2_q;
            else                   run_d = run_q + 1'b1;
        end
    end

    assign rise        = f_q & ~fdly_q;
    assign fall        = ~f_q & fdly_q;
    assign edge_any    = rise | fall;
    assign timeout_hit = ~edge_any && (idle_q == TO_LAST);
    assign frame_ok    = (hi_q >= W_LO) && (hi_q <= W_HI) &&
                         (per_q >= P_LO) && (per_q <= P_HI);

    // Frame FSM, counters, frame evaluation and loss-of-signal next-state logic.
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        per_d    = per_q;
        width_d  = width_q;
        period_d = period_q;
        pos_d    = pos_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        lost_d   = lost_q;
        idle_d   = edge_any ? 26'd0 : ((idle_q >= TO_MAX) ? idle_q : idle_q + 26'd1);
        // A rise is only trusted once a genuine low has been seen since reset,
        // so a pulse already in progress at reset release is discarded.
        armed_d  = armed_q | (warm_q[1] & ~s2_q & ~f_q);

        case (state_q)
            ST_IDLE: begin
                if (rise && armed_q) begin
                    state_d = ST_HIGH;
                    hi_d    = 26'd1;
                    per_d   = 26'd1;
                end
            end
            ST_HIGH: begin
                per_d = sat_inc(per_q);
                if (fall) state_d = ST_LOW;
                else      hi_d    = sat_inc(hi_q);
            end
            ST_LOW: begin
                if (rise) begin
                    if (frame_ok) begin
                        width_d  = hi_q;
                        period_d = per_q;
                        pos_d    = classify(hi_q);
                        valid_d  = 1'b1;
                        lost_d   = 1'b0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    hi_d    = 26'd1;
                    per_d   = 26'd1;
                    state_d = ST_HIGH;
                end else begin
                    per_d = sat_inc(per_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // timeout_hit already excludes edge cycles, so an edge always wins.
        if (timeout_hit) begin
            state_d = ST_IDLE;
            lost_d  = 1'b1;
            pos_d   = POS_NONE;
        end
    end

    // State, filter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q      <= 1'b0;
            fdly_q   <= 1'b0;
            run_q    <= '0;
            armed_q  <= 1'b0;
            state_q  <= ST_IDLE;
            hi_q     <= 26'd0;
            per_q    <= 26'd0;
            idle_q   <= 26'd0;
            width_q  <= 26'd0;
            period_q <= 26'd0;
            pos_q    <= POS_NONE;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            lost_q   <= 1'b1;
        end else begin
            f_q      <= f_d;
            fdly_q   <= f_q;
            run_q    <= run_d;
            armed_q  <= armed_d;
            state_q  <= state_d;
            hi_q     <= hi_d;
            per_q    <= per_d;
            idle_q   <= idle_d;
            width_q  <= width_d;
            period_q <= period_d;
            pos_q    <= pos_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            lost_q   <= lost_d;
        end
    end

    assign width       = width_q;
    assign period      = period_q;
    assign pos_state   = pos_q;
    assign valid       = valid_q;
    assign frame_error = ferr_q;
    assign signal_lost = lost_q;

endmodule

// File: doc/servo_pwm_capture.md
Name: servo_pwm_capture

Overview:
Receive-side counterpart of the servo PWM generator. Samples an incoming servo-style PWM line, deglitches it, and measures high time and period in clk cycles. Validates each frame against the servo timing window and classifies the commanded position as CLOSED/MID/OPEN. Used for loopback self-test of the servo output and for reading external servo commands; flags loss of signal.

Parameters:
PWM_PERIOD, 1_000_000, nominal frame period in clk cycles (20 ms @ 50 MHz)
MIN_DUTY, 50_000, nominal closed-position pulse width in cycles
MAX_DUTY, 100_000, nominal open-position pulse width in cycles
WIDTH_TOL, 5_000, allowed width deviation outside [MIN_DUTY, MAX_DUTY] and classification band
PERIOD_TOL, 50_000, allowed period deviation from PWM_PERIOD
FILTER_LEN, 8, consecutive stable cycles required before filtered level changes (≥1)
TIMEOUT, 2_000_000, cycles without a filtered edge before signal is declared lost (< 2^26)

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous reset, active-high
pwm_in  input  1  asynchronous PWM line
width  output  26  last valid measured high time, cycles
period  output  26  last valid measured period, cycles
pos_state  output  2  00 NONE, 01 CLOSED, 10 OPEN, 11 MID
valid  output  1  one-cycle strobe: width/period/pos_state updated
frame_error  output  1  one-cycle strobe: completed frame out of window
signal_lost  output  1  level: no filtered edge for TIMEOUT cycles

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (clk, rst). Immediately on rst: width=0, period=0, pos_state=00, valid=0, frame_error=0, signal_lost=1; sync flops, filtered level and all counters 0; FSM=IDLE. Same regardless of state when asserted mid-frame.
- Input path: 2-flop synchronizer, then filter. Filtered level f toggles only after synchronized input differs from f for FILTER_LEN consecutive cycles; any matching cycle clears the run count. Pulses/gaps shorter than FILTER_LEN cycles are suppressed. Delay is symmetric on both edges, so a source high for D cycles measures exactly D.
- Edge detect on f: rise = f & ~f_d, fall = ~f & f_d.
- FSM:
  IDLE: ignore everything until rise (a pulse already high at reset release is discarded); on rise -> HIGH, hi_cnt=1, per_cnt=1.
  HIGH: hi_cnt and per_cnt increment each cycle; on fall -> LOW (hi_cnt frozen).
  LOW: per_cnt increments; on rise: evaluate frame, then restart hi_cnt=1, per_cnt=1, -> HIGH.
- Frame evaluation (at rise in LOW): ok = (MIN_DUTY-WIDTH_TOL ≤ hi_cnt ≤ MAX_DUTY+WIDTH_TOL) and (PWM_PERIOD-PERIOD_TOL ≤ per_cnt ≤ PWM_PERIOD+PERIOD_TOL), per_cnt counted including the final LOW cycle. ok: next cycle width=hi_cnt, period=per_cnt, pos_state updated, valid=1, signal_lost=0. Not ok: next cycle frame_error=1; width/period/pos_state hold.
- Classification: width ≤ MIN_DUTY+WIDTH_TOL -> CLOSED; width ≥ MAX_DUTY-WIDTH_TOL -> OPEN; else MID.
- First valid occurs at the second filtered rise after reset/loss (one full period needed).
- Timeout: idle counter clears on any filtered edge, else increments (saturating). Reaching TIMEOUT: signal_lost=1, pos_state=00, FSM=IDLE; width/period hold. Edge and timeout in same cycle: edge wins, no loss.
- Constant-high or constant-low input both end in signal_lost.
- valid and frame_error never asserted together; each high exactly one cycle.

Test Plan:
- Reset, drive PWM period 1_000_000, high 100_000 -> first valid after 2nd rise; width=100_000, period=1_000_000, pos_state=10, signal_lost 1->0.
- Switch to high 50_000 -> next valid: width=50_000, pos_state=01; high 75_000 -> pos_state=11.
- High 150_000 (or period 800_000) -> frame_error one cycle, width/period/pos_state unchanged, no valid.
- Inject 3-cycle glitch low inside high pulse and 5-cycle spike high in low phase (FILTER_LEN=8) -> measurements unchanged, valid as normal.
- Hold pwm_in low after valid frames -> signal_lost=1 and pos_state=00 exactly TIMEOUT cycles after last filtered edge; resume PWM -> valid on 2nd rise.
- Assert rst mid-HIGH phase -> all outputs at reset values immediately; release with pwm_in high -> that partial pulse ignored, first valid one full period after next rise.
